// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings and types for the slave multiplexer and its default slave.
package ahblite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam int NUM_PORTS = 5;

   typedef enum logic [1:0] {
      DS_IDLE = 2'b00,
      DS_ERR1 = 2'b01,
      DS_ERR2 = 2'b10
   } ds_state_e;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle AHB ERROR response.
module ahblite_default_slave
   import ahblite_pkg::*;
(
   input  logic HCLK,
   input  logic HRESET,
   input  logic HREADY,
   input  logic sel_default,
   output logic HREADYOUT,
   output logic HRESP
);

   ds_state_e state, state_nxt;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) state <= DS_IDLE;
      else        state <= state_nxt;
   end

   // ERR1 is the wait cycle, ERR2 completes; a new unmapped capture in ERR2 restarts at ERR1.
   always_comb begin
      state_nxt = state;
      HREADYOUT = 1'b1;
      HRESP     = HRESP_OKAY;
      case (state)
         DS_IDLE: begin
            if (HREADY && sel_default) state_nxt = DS_ERR1;
         end
         DS_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRESP_ERROR;
            state_nxt = DS_ERR2;
         end
         DS_ERR2: begin
            HRESP     = HRESP_ERROR;
            state_nxt = (HREADY && sel_default) ? DS_ERR1 : DS_IDLE;
         end
         default: state_nxt = DS_IDLE;
      endcase
   end

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite slave-to-master response multiplexer with address-phase select capture and default slave.
module ahblite_slave_mux
   import ahblite_pkg::*;
#(
   parameter bit Port0_en = 1'b1,
   parameter bit Port1_en = 1'b1,
   parameter bit Port2_en = 1'b0,
   parameter bit Port3_en = 1'b1,
   parameter bit Port4_en = 1'b0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        P0_HSEL,
   input  logic        P1_HSEL,
   input  logic        P2_HSEL,
   input  logic        P3_HSEL,
   input  logic        P4_HSEL,
   input  logic [1:0]  HTRANS,
   input  logic        P0_HREADYOUT,
   input  logic        P1_HREADYOUT,
   input  logic        P2_HREADYOUT,
   input  logic        P3_HREADYOUT,
   input  logic        P4_HREADYOUT,
   input  logic        P0_HRESP,
   input  logic        P1_HRESP,
   input  logic        P2_HRESP,
   input  logic        P3_HRESP,
   input  logic        P4_HRESP,
   input  logic [31:0] P0_HRDATA,
   input  logic [31:0] P1_HRDATA,
   input  logic [31:0] P2_HRDATA,
   input  logic [31:0] P3_HRDATA,
   input  logic [31:0] P4_HRDATA,
   output logic        HREADY,
   output logic        HRESP,
   output logic [31:0] HRDATA
);

   logic [NUM_PORTS-1:0] hsel_g;
   logic [NUM_PORTS-1:0] ready_v;
   logic [NUM_PORTS-1:0] resp_v;
   logic [31:0]          rdata_v [NUM_PORTS];
   logic [NUM_PORTS:0]   dsel, dsel_nxt;
   logic                 found;
   logic                 ds_ready, ds_resp;

   assign hsel_g  = {P4_HSEL & Port4_en, P3_HSEL & Port3_en, P2_HSEL & Port2_en,
                     P1_HSEL & Port1_en, P0_HSEL & Port0_en};
   assign ready_v = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
   assign resp_v  = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};
   assign rdata_v[0] = P0_HRDATA;
   assign rdata_v[1] = P1_HRDATA;
   assign rdata_v[2] = P2_HRDATA;
   assign rdata_v[3] = P3_HRDATA;
   assign rdata_v[4] = P4_HRDATA;

   // Lowest gated select wins; the default slave only claims active (NONSEQ/SEQ) transfers.
   always_comb begin
      dsel_nxt = '0;
      found    = 1'b0;
      for (int n = 0; n < NUM_PORTS; n++) begin
         if (hsel_g[n] && !found) begin
            dsel_nxt[n] = 1'b1;
            found       = 1'b1;
         end
      end
      if (!found && HTRANS[1]) dsel_nxt[NUM_PORTS] = 1'b1;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)      dsel <= '0;
      else if (HREADY) dsel <= dsel_nxt;
   end

   ahblite_default_slave u_default_slave (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HREADY      (HREADY),
      .sel_default (dsel_nxt[NUM_PORTS]),
      .HREADYOUT   (ds_ready),
      .HRESP       (ds_resp)
   );

   // Data-phase return path; an empty select completes with a zero-wait OKAY.
   always_comb begin
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      HRDATA = '0;
      for (int n = 0; n < NUM_PORTS; n++) begin
         if (dsel[n]) begin
            HREADY = ready_v[n];
            HRESP  = resp_v[n];
            HRDATA = rdata_v[n];
         end
      end
      if (dsel[NUM_PORTS]) begin
         HREADY = ds_ready;
         HRESP  = ds_resp;
      end
   end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench for ahblite_slave_mux with default port enables (ports 2 and 4 disabled).
module tb_ahblite_slave_mux;
   import ahblite_pkg::*;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL;
   logic [1:0]  HTRANS;
   logic        P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT;
   logic        P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP;
   logic [31:0] P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA, P4_HRDATA;
   logic        HREADY, HRESP;
   logic [31:0] HRDATA;

   int vectors    = 0;
   int miscompares = 0;

   ahblite_slave_mux dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .P0_HSEL(P0_HSEL), .P1_HSEL(P1_HSEL), .P2_HSEL(P2_HSEL), .P3_HSEL(P3_HSEL), .P4_HSEL(P4_HSEL),
      .HTRANS(HTRANS),
      .P0_HREADYOUT(P0_HREADYOUT), .P1_HREADYOUT(P1_HREADYOUT), .P2_HREADYOUT(P2_HREADYOUT),
      .P3_HREADYOUT(P3_HREADYOUT), .P4_HREADYOUT(P4_HREADYOUT),
      .P0_HRESP(P0_HRESP), .P1_HRESP(P1_HRESP), .P2_HRESP(P2_HRESP), .P3_HRESP(P3_HRESP), .P4_HRESP(P4_HRESP),
      .P0_HRDATA(P0_HRDATA), .P1_HRDATA(P1_HRDATA), .P2_HRDATA(P2_HRDATA), .P3_HRDATA(P3_HRDATA),
      .P4_HRDATA(P4_HRDATA),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check the full response triple in one go.
   task automatic chk_rsp(input string tag, input logic rdy, input logic rsp, input logic [31:0] data);
      chk({tag, ".hready"}, {31'h0, HREADY}, {31'h0, rdy});
      chk({tag, ".hresp"},  {31'h0, HRESP},  {31'h0, rsp});
      chk({tag, ".hrdata"}, HRDATA, data);
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle_bus();
      {P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL} = '0;
      HTRANS = HTRANS_IDLE;
   endtask

   initial begin
      HRESET = 1'b1;
      idle_bus();
      {P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT, P4_HREADYOUT} = 5'b11111;
      {P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP} = '0;
      P0_HRDATA = 32'hDEADBEEF;
      P1_HRDATA = 32'h12345678;
      P2_HRDATA = 32'hAAAA2222;
      P3_HRDATA = 32'hCAFE0003;
      P4_HRDATA = 32'h44444444;
      #2;
      chk_rsp("reset", 1'b1, 1'b0, 32'h0);
      P0_HSEL = 1'b1;
      HTRANS  = HTRANS_NONSEQ;
      tick();
      chk_rsp("reset_held", 1'b1, 1'b0, 32'h0);
      #2 HRESET = 1'b0;

      // Read RAMCODE: output appears in the cycle after the address phase
      tick();
      idle_bus();
      #1;
      chk_rsp("p0_read", 1'b1, 1'b0, 32'hDEADBEEF);

      // UART with three wait states while P0 is pending
      P3_HSEL = 1'b1;
      HTRANS  = HTRANS_NONSEQ;
      tick();
      P3_HSEL = 1'b0;
      P0_HSEL = 1'b1;
      P3_HREADYOUT = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_rsp($sformatf("p3_wait%0d", i), 1'b0, 1'b0, 32'hCAFE0003);
         tick();
      end
      P3_HREADYOUT = 1'b1;
      #1;
      chk_rsp("p3_done", 1'b1, 1'b0, 32'hCAFE0003);
      tick();
      idle_bus();
      #1;
      chk_rsp("p0_after_p3", 1'b1, 1'b0, 32'hDEADBEEF);

      // Priority: P1 and P3 both selected, P1 wins; error passthrough from P1
      P1_HSEL = 1'b1;
      P3_HSEL = 1'b1;
      HTRANS  = HTRANS_SEQ;
      tick();
      idle_bus();
      P1_HRESP = 1'b1;
      #1;
      chk_rsp("prio_p1", 1'b1, 1'b1, 32'h12345678);
      P1_HRESP = 1'b0;
      tick();
      chk_rsp("idle_okay", 1'b1, 1'b0, 32'h0);

      // Unmapped NONSEQ: two-cycle ERROR, then OKAY
      HTRANS = HTRANS_NONSEQ;
      tick();
      HTRANS = HTRANS_IDLE;
      #1;
      chk_rsp("unm_err1", 1'b0, 1'b1, 32'h0);
      tick();
      chk_rsp("unm_err2", 1'b1, 1'b1, 32'h0);
      tick();
      chk_rsp("unm_after", 1'b1, 1'b0, 32'h0);

      // Unmapped BUSY and IDLE, and disabled P4 with IDLE: zero-wait OKAY
      HTRANS = HTRANS_BUSY;
      tick();
      chk_rsp("busy_okay", 1'b1, 1'b0, 32'h0);
      HTRANS  = HTRANS_IDLE;
      P4_HSEL = 1'b1;
      tick();
      idle_bus();
      #1;
      chk_rsp("p4_idle_okay", 1'b1, 1'b0, 32'h0);

      // Back-to-back unmapped, then P1 read
      HTRANS = HTRANS_NONSEQ;
      tick();
      chk_rsp("b2b_err1a", 1'b0, 1'b1, 32'h0);
      tick();
      chk_rsp("b2b_err2a", 1'b1, 1'b1, 32'h0);
      tick();
      P1_HSEL = 1'b1;
      #1;
      chk_rsp("b2b_err1b", 1'b0, 1'b1, 32'h0);
      tick();
      chk_rsp("b2b_err2b", 1'b1, 1'b1, 32'h0);
      tick();
      idle_bus();
      #1;
      chk_rsp("b2b_p1", 1'b1, 1'b0, 32'h12345678);

      // Disabled P2 with NONSEQ gets an ERROR; reset in ERR1 aborts asynchronously
      P2_HSEL = 1'b1;
      HTRANS  = HTRANS_NONSEQ;
      tick();
      idle_bus();
      #1;
      chk_rsp("p2_disabled_err1", 1'b0, 1'b1, 32'h0);
      HRESET = 1'b1;
      #1;
      chk_rsp("reset_in_err1", 1'b1, 1'b0, 32'h0);
      #1 HRESET = 1'b0;
      tick();
      chk_rsp("post_reset_idle", 1'b1, 1'b0, 32'h0);

      // First capture after reset
      P0_HSEL = 1'b1;
      HTRANS  = HTRANS_NONSEQ;
      tick();
      idle_bus();
      #1;
      chk_rsp("post_reset_p0", 1'b1, 1'b0, 32'hDEADBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
